// File: rtl/mod_updown_counter.sv
// mod_updown_counter
//   Bidirectional modulo counter used as a timing/event-count primitive.
//   The count runs over 0..MODULUS-1, and MODULUS does not have to be a power of two.
//   A prescaler decides which enabled cycles produce a count tick.
//   A synchronous parallel load, clamped to the count range, takes priority over ticks.
//   At the terminal value the counter either wraps or saturates, selected by mode_sat.
//   A registered carry pulse on each wrap lets stages be cascaded.
//   A sticky overflow flag records any tick taken at the terminal value.
//
// Parameters
//   MODULUS   count range 0..MODULUS-1 (>= 2)
//   PRESCALE  enabled cycles per count tick (>= 1)
//   N, P      derived count / prescaler widths (not for override)
//
// Ports
//   clk       rising-edge clock
//   reset     synchronous, active-high; overrides every other input
//   enable    count enable; advances the prescaler
//   up_down   1 = count up, 0 = count down
//   load      parallel load strobe (does not need enable)
//   load_val  value to load, clamped to MODULUS-1
//   mode_sat  0 = wrap at terminal, 1 = hold at terminal
//   clr_ovf   clears the sticky overflow flag
//   count     current count
//   TC        terminal count for the current direction (combinational)
//   carry     one-cycle registered pulse following a wrap
//   ovf       sticky overflow flag
module mod_updown_counter #(
    parameter int unsigned MODULUS  = 16,
    parameter int unsigned PRESCALE = 1,
    localparam int unsigned N = (MODULUS > 2) ? $clog2(MODULUS) : 1,
    localparam int unsigned P = (PRESCALE > 2) ? $clog2(PRESCALE) : 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    input  logic         up_down,
    input  logic         load,
    input  logic [N-1:0] load_val,
    input  logic         mode_sat,
    input  logic         clr_ovf,
    output logic [N-1:0] count,
    output logic         TC,
    output logic         carry,
    output logic         ovf
);

    localparam logic [N-1:0] CNT_MAX  = N'(MODULUS - 1);
    localparam logic [P-1:0] PRES_MAX = P'(PRESCALE - 1);

    logic [P-1:0] presc;
    logic         tick;
    logic         at_term;
    logic         wrap;
    logic [N-1:0] load_clamped;
    logic [N-1:0] count_next;

    always_comb begin
        tick         = enable && (presc == PRES_MAX);
        at_term      = up_down ? (count == CNT_MAX) : (count == '0);
        TC           = at_term;
        wrap         = tick && at_term && !mode_sat;
        load_clamped = (load_val > CNT_MAX) ? CNT_MAX : load_val;

        count_next = count;
        if (tick) begin
            if (at_term) begin
                // Saturate mode keeps the default (hold).
                if (!mode_sat) begin
                    count_next = up_down ? '0 : CNT_MAX;
                end
            end else begin
                count_next = up_down ? count + 1'b1 : count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            presc <= '0;
            carry <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            if (load) begin
                // A load discards any tick issued this cycle and restarts the prescaler.
                count <= load_clamped;
                presc <= '0;
                carry <= 1'b0;
            end else begin
                if (enable) begin
                    presc <= tick ? '0 : presc + 1'b1;
                end
                count <= count_next;
                carry <= wrap;
            end

            // Setting the flag wins over clearing it in the same cycle.
            if (!load && tick && at_term) begin
                ovf <= 1'b1;
            end else if (clr_ovf) begin
                ovf <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mod_updown_counter.sv
// tb_mod_updown_counter
//   Drives three counter configurations with directed vectors:
//     dut_a  MODULUS=10, PRESCALE=1
//     dut_b  MODULUS=10, PRESCALE=3
//     dut_c  MODULUS=2,  PRESCALE=1
//   Each stimulus step queues the hand-computed post-edge state. A separate monitor
//   pops each queued entry after the clock edge and compares it with the selected DUT.
module tb_mod_updown_counter;

    logic clk;

    logic       rst_a, en_a, ud_a, ld_a, sat_a, clr_a;
    logic [3:0] lv_a, count_a;
    logic       tc_a, carry_a, ovf_a;

    logic       rst_b, en_b, ud_b, ld_b, sat_b, clr_b;
    logic [3:0] lv_b, count_b;
    logic       tc_b, carry_b, ovf_b;

    logic       rst_c, en_c, ud_c, ld_c, sat_c, clr_c;
    logic [0:0] lv_c, count_c;
    logic       tc_c, carry_c, ovf_c;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [1:0] dut;
        logic [3:0] count;
        logic       tc;
        logic       carry;
        logic       ovf;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];

    mod_updown_counter #(.MODULUS(10), .PRESCALE(1)) dut_a (
        .clk(clk), .reset(rst_a), .enable(en_a), .up_down(ud_a), .load(ld_a),
        .load_val(lv_a), .mode_sat(sat_a), .clr_ovf(clr_a),
        .count(count_a), .TC(tc_a), .carry(carry_a), .ovf(ovf_a)
    );

    mod_updown_counter #(.MODULUS(10), .PRESCALE(3)) dut_b (
        .clk(clk), .reset(rst_b), .enable(en_b), .up_down(ud_b), .load(ld_b),
        .load_val(lv_b), .mode_sat(sat_b), .clr_ovf(clr_b),
        .count(count_b), .TC(tc_b), .carry(carry_b), .ovf(ovf_b)
    );

    mod_updown_counter #(.MODULUS(2), .PRESCALE(1)) dut_c (
        .clk(clk), .reset(rst_c), .enable(en_c), .up_down(ud_c), .load(ld_c),
        .load_val(lv_c), .mode_sat(sat_c), .clr_ovf(clr_c),
        .count(count_c), .TC(tc_c), .carry(carry_c), .ovf(ovf_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs into DUT d (others idle) and queue the expected post-edge state.
    task automatic step(input int d, input bit rst, input bit en, input bit ud, input bit ld,
                        input int lv, input bit sat, input bit clr,
                        input int ec, input bit etc, input bit ecar, input bit eovf,
                        input string name);
        exp_t e;
        @(negedge clk);
        rst_a = 1'b0; en_a = 1'b0; ld_a = 1'b0; clr_a = 1'b0;
        rst_b = 1'b0; en_b = 1'b0; ld_b = 1'b0; clr_b = 1'b0;
        rst_c = 1'b0; en_c = 1'b0; ld_c = 1'b0; clr_c = 1'b0;
        case (d)
            0: begin rst_a = rst; en_a = en; ud_a = ud; ld_a = ld; lv_a = 4'(lv); sat_a = sat; clr_a = clr; end
            1: begin rst_b = rst; en_b = en; ud_b = ud; ld_b = ld; lv_b = 4'(lv); sat_b = sat; clr_b = clr; end
            default: begin rst_c = rst; en_c = en; ud_c = ud; ld_c = ld; lv_c = 1'(lv); sat_c = sat; clr_c = clr; end
        endcase
        e.dut   = 2'(d);
        e.count = 4'(ec);
        e.tc    = etc;
        e.carry = ecar;
        e.ovf   = eovf;
        exp_q.push_back(e);
        name_q.push_back(name);
    endtask

    // Monitor: checks every queued expectation just after the active edge.
    initial begin : monitor
        exp_t       e;
        string      nm;
        logic [3:0] ac;
        logic       atc, acar, aovf;
        forever begin
            @(posedge clk);
            #1;
            while (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                case (e.dut)
                    2'd0:    begin ac = count_a; atc = tc_a; acar = carry_a; aovf = ovf_a; end
                    2'd1:    begin ac = count_b; atc = tc_b; acar = carry_b; aovf = ovf_b; end
                    default: begin ac = {3'b000, count_c}; atc = tc_c; acar = carry_c; aovf = ovf_c; end
                endcase
                checks++;
                if (ac !== e.count || atc !== e.tc || acar !== e.carry || aovf !== e.ovf) begin
                    errors++;
                    $display("FAIL %s dut%0d: got count=%0d TC=%0b carry=%0b ovf=%0b, want count=%0d TC=%0b carry=%0b ovf=%0b",
                             nm, e.dut, ac, atc, acar, aovf, e.count, e.tc, e.carry, e.ovf);
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        rst_a = 1'b0; en_a = 1'b0; ud_a = 1'b1; ld_a = 1'b0; lv_a = '0; sat_a = 1'b0; clr_a = 1'b0;
        rst_b = 1'b0; en_b = 1'b0; ud_b = 1'b1; ld_b = 1'b0; lv_b = '0; sat_b = 1'b0; clr_b = 1'b0;
        rst_c = 1'b0; en_c = 1'b0; ud_c = 1'b1; ld_c = 1'b0; lv_c = '0; sat_c = 1'b0; clr_c = 1'b0;

        //    d rst en ud ld lv sat clr  cnt tc car ovf
        // Up/wrap run from reset, MODULUS=10
        step(0, 1, 0, 1, 0, 0, 0, 0,   0, 0, 0, 0, "reset");
        for (int i = 1; i <= 12; i++)
            step(0, 0, 1, 1, 0, 0, 0, 0, i % 10, (i % 10) == 9, i == 10, i >= 10, "t1_up_wrap");

        // Down/wrap from 0
        step(0, 1, 0, 0, 0, 0, 0, 0,   0, 1, 0, 0, "t2_reset");
        step(0, 0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 0, "t2_tc_at_0");
        step(0, 0, 1, 0, 0, 0, 0, 0,   9, 0, 1, 1, "t2_down_wrap");
        step(0, 0, 1, 0, 0, 0, 0, 0,   8, 0, 0, 1, "t2_down");

        // Saturate mode, overflow set/clear
        step(0, 1, 0, 1, 0, 0, 1, 0,   0, 0, 0, 0, "t3_reset");
        step(0, 0, 0, 1, 1, 8, 1, 0,   8, 0, 0, 0, "t3_load8");
        step(0, 0, 1, 1, 0, 0, 1, 0,   9, 1, 0, 0, "t3_tick_to_9");
        for (int i = 0; i < 4; i++)
            step(0, 0, 1, 1, 0, 0, 1, 0, 9, 1, 0, 1, "t3_sat_hold");
        step(0, 0, 0, 1, 0, 0, 1, 1,   9, 1, 0, 0, "t3_clr_ovf");
        step(0, 0, 1, 1, 0, 0, 1, 1,   9, 1, 0, 1, "t3_set_beats_clr");
        step(0, 0, 0, 0, 1, 0, 1, 0,   0, 1, 0, 1, "t3_load_keeps_ovf");
        step(0, 0, 0, 0, 0, 0, 1, 1,   0, 1, 0, 0, "t3_clr2");
        step(0, 0, 1, 0, 0, 0, 1, 0,   0, 1, 0, 1, "t3_sat_down_hold");

        // Load clamp, load priority, reset mid-count and mid-wrap
        step(0, 0, 0, 1, 1, 15, 0, 0,  9, 1, 0, 1, "t5_load_clamp");
        step(0, 0, 1, 1, 1, 3, 0, 0,   3, 0, 0, 1, "t5_load_beats_tick");
        step(0, 0, 0, 1, 1, 5, 0, 0,   5, 0, 0, 1, "t5_load5");
        step(0, 0, 1, 1, 0, 0, 0, 0,   6, 0, 0, 1, "t5_tick6");
        step(0, 1, 1, 1, 0, 0, 0, 0,   0, 0, 0, 0, "t5_reset_mid_count");
        step(0, 0, 0, 1, 1, 9, 0, 0,   9, 1, 0, 0, "t5_load9");
        step(0, 0, 1, 1, 0, 0, 0, 0,   0, 0, 1, 1, "t5_wrap");
        step(0, 1, 1, 1, 0, 0, 0, 0,   0, 0, 0, 0, "t5_reset_mid_wrap");
        step(0, 0, 0, 1, 1, 9, 0, 0,   9, 1, 0, 0, "t5_load9b");
        step(0, 0, 1, 1, 1, 3, 0, 0,   3, 0, 0, 0, "t5_load_drops_tick");

        // Prescaler, PRESCALE=3
        step(1, 1, 0, 1, 0, 0, 0, 0,   0, 0, 0, 0, "t4_reset");
        step(1, 0, 1, 1, 0, 0, 0, 0,   0, 0, 0, 0, "t4_en1");
        step(1, 0, 1, 1, 0, 0, 0, 0,   0, 0, 0, 0, "t4_en2");
        step(1, 0, 0, 1, 0, 0, 0, 0,   0, 0, 0, 0, "t4_hold");
        step(1, 0, 1, 1, 0, 0, 0, 0,   1, 0, 0, 0, "t4_tick");
        step(1, 0, 1, 1, 0, 0, 0, 0,   1, 0, 0, 0, "t4_p1");
        step(1, 0, 1, 0, 0, 0, 0, 0,   1, 0, 0, 0, "t4_dir_change");
        step(1, 0, 1, 0, 0, 0, 0, 0,   0, 1, 0, 0, "t4_down_tick");
        step(1, 0, 1, 1, 0, 0, 0, 0,   0, 0, 0, 0, "t4_p1b");
        step(1, 0, 1, 1, 0, 0, 0, 0,   0, 0, 0, 0, "t4_p2b");
        step(1, 0, 1, 1, 1, 7, 0, 0,   7, 0, 0, 0, "t4_load_beats_tick");
        step(1, 0, 1, 1, 0, 0, 0, 0,   7, 0, 0, 0, "t4_restart_p1");
        step(1, 0, 1, 1, 0, 0, 0, 0,   7, 0, 0, 0, "t4_restart_p2");
        step(1, 0, 1, 1, 0, 0, 0, 0,   8, 0, 0, 0, "t4_restart_tick");

        // MODULUS=2 back-to-back wrap
        step(2, 1, 0, 1, 0, 0, 0, 0,   0, 0, 0, 0, "t6_reset");
        for (int i = 1; i <= 4; i++)
            step(2, 0, 1, 1, 0, 0, 0, 0, i % 2, (i % 2) == 1, (i % 2) == 0, i >= 2, "t6_mod2");
        step(2, 0, 0, 1, 0, 0, 0, 0,   0, 0, 0, 1, "t6_idle");

        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
